// File: rtl/onehot_decoder_pipe_if.sv
`default_nettype none
// ============================================================================
// onehot_decoder_pipe_if
// Valid/ready request and result bundle for the index-to-mask decoder.
// Revision: 1.0
// ============================================================================
interface onehot_decoder_pipe_if #(
  parameter int IDX_W = 6,
  parameter int OUT_W = 64,
  parameter int WIN_W = 16,
  parameter int SEQ_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] in_idx;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_vec;
  logic [WIN_W-1:0] out_win;
  logic             out_oor;
  logic [SEQ_W-1:0] out_seq;

  modport slave (
    input  in_valid, in_idx, in_mode, out_ready,
    output in_ready, out_valid, out_vec, out_win, out_oor, out_seq
  );

  modport master (
    output in_valid, in_idx, in_mode, out_ready,
    input  in_ready, out_valid, out_vec, out_win, out_oor, out_seq
  );
endinterface
`default_nettype wire

// File: rtl/onehot_decoder_pipe.sv
`default_nettype none
// ============================================================================
// onehot_decoder_pipe
// Two-stage pipelined index decoder: one-hot / low / high thermometer masks,
// window extraction, out-of-range flag and per-item sequence tag.
// Revision: 1.0
// ============================================================================
module onehot_decoder_pipe #(
  parameter int IDX_W   = 6,
  parameter int OUT_W   = 64,
  parameter int WIN_LSB = 47,
  parameter int WIN_W   = 16,
  parameter int SEQ_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  onehot_decoder_pipe_if.slave bus
);

  // Extra bit keeps OUT_W representable when OUT_W == 2**IDX_W.
  localparam logic [IDX_W:0] C_OUT_W_EXT = (IDX_W+1)'(OUT_W);
  localparam logic [1:0]     C_MODE_ONE  = 2'b00;
  localparam logic [1:0]     C_MODE_LOW  = 2'b01;
  localparam logic [1:0]     C_MODE_HIGH = 2'b10;

  logic             r_s1_valid;
  logic [IDX_W-1:0] r_s1_idx;
  logic [1:0]       r_s1_mode;
  logic             r_s1_oor;
  logic [SEQ_W-1:0] r_s1_seq;
  logic [SEQ_W-1:0] r_seq_cnt;

  logic             r_out_valid;
  logic [OUT_W-1:0] r_out_vec;
  logic             r_out_oor;
  logic [SEQ_W-1:0] r_out_seq;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic             w_in_fire;
  logic             w_in_oor;
  logic [IDX_W:0]   w_s1_idx_ext;
  logic [OUT_W-1:0] w_mask;

  assign w_s2_adv     = !r_out_valid || bus.out_ready;
  assign w_s1_adv     = !r_s1_valid || w_s2_adv;
  assign w_in_fire    = bus.in_valid && w_s1_adv;
  assign w_in_oor     = {1'b0, bus.in_idx} >= C_OUT_W_EXT;
  assign w_s1_idx_ext = {1'b0, r_s1_idx};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_idx   <= '0;
      r_s1_mode  <= '0;
      r_s1_oor   <= 1'b0;
      r_s1_seq   <= '0;
      r_seq_cnt  <= '0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= bus.in_valid;
      end
      if (w_in_fire) begin
        r_s1_idx  <= bus.in_idx;
        r_s1_mode <= bus.in_mode;
        r_s1_oor  <= w_in_oor;
        r_s1_seq  <= r_seq_cnt;
        r_seq_cnt <= r_seq_cnt + 1'b1;
      end
    end
  end

  // Out-of-range indices saturate the low thermometer; every other mode gives zero.
  for (genvar i = 0; i < OUT_W; i++) begin : g_bit
    localparam logic [IDX_W:0] C_POS = (IDX_W+1)'(i);
    assign w_mask[i] = r_s1_oor ? (r_s1_mode == C_MODE_LOW) :
                       (r_s1_mode == C_MODE_ONE)  ? (w_s1_idx_ext == C_POS) :
                       (r_s1_mode == C_MODE_LOW)  ? (C_POS <= w_s1_idx_ext) :
                       (r_s1_mode == C_MODE_HIGH) ? (C_POS >= w_s1_idx_ext) :
                       1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_vec   <= '0;
      r_out_oor   <= 1'b0;
      r_out_seq   <= '0;
    end else begin
      if (w_s2_adv) begin
        r_out_valid <= r_s1_valid;
      end
      if (w_s2_adv && r_s1_valid) begin
        r_out_vec <= w_mask;
        r_out_oor <= r_s1_oor;
        r_out_seq <= r_s1_seq;
      end
    end
  end

  assign bus.in_ready  = w_s1_adv;
  assign bus.out_valid = r_out_valid;
  assign bus.out_vec   = r_out_vec;
  assign bus.out_win   = r_out_vec[WIN_LSB +: WIN_W];
  assign bus.out_oor   = r_out_oor;
  assign bus.out_seq   = r_out_seq;

endmodule
`default_nettype wire

// File: tb/tb_onehot_decoder_pipe.sv
`default_nettype none
// ============================================================================
// tb_onehot_decoder_pipe
// Directed bench: default configuration plus a 40-bit mask instance.
// Revision: 1.0
// ============================================================================
module tb_onehot_decoder_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   n_sent;
  int   n_got;
  logic fire;

  always #5 clk = ~clk;

  onehot_decoder_pipe_if #(.IDX_W(6), .OUT_W(64), .WIN_W(16), .SEQ_W(8)) ifa ();
  onehot_decoder_pipe_if #(.IDX_W(6), .OUT_W(40), .WIN_W(16), .SEQ_W(8)) ifb ();

  onehot_decoder_pipe #(.IDX_W(6), .OUT_W(64), .WIN_LSB(47), .WIN_W(16), .SEQ_W(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  onehot_decoder_pipe #(.IDX_W(6), .OUT_W(40), .WIN_LSB(8), .WIN_W(16), .SEQ_W(8)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_a(input logic [5:0] idx, input logic [1:0] mode);
    ifa.in_valid = 1'b1;
    ifa.in_idx   = idx;
    ifa.in_mode  = mode;
    tick();
    ifa.in_valid = 1'b0;
    ifa.in_idx   = ~idx;
    ifa.in_mode  = ~mode;
    tick();
  endtask

  task automatic send_b(input logic [5:0] idx, input logic [1:0] mode);
    ifb.in_valid = 1'b1;
    ifb.in_idx   = idx;
    ifb.in_mode  = mode;
    tick();
    ifb.in_valid = 1'b0;
    ifb.in_idx   = ~idx;
    ifb.in_mode  = ~mode;
    tick();
  endtask

  task automatic pulse_reset;
    rst = 1'b1;
    #1;
    chk("rst_valid", 64'(ifa.out_valid), 64'd0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    ifa.in_valid = 1'b0; ifa.in_idx = '0; ifa.in_mode = '0; ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.in_idx = '0; ifb.in_mode = '0; ifb.out_ready = 1'b1;

    // Reset state
    repeat (3) tick();
    chk("reset_valid", 64'(ifa.out_valid), 64'd0);
    chk("reset_vec",   ifa.out_vec,        64'd0);
    chk("reset_win",   64'(ifa.out_win),   64'd0);
    chk("reset_oor",   64'(ifa.out_oor),   64'd0);
    chk("reset_seq",   64'(ifa.out_seq),   64'd0);
    chk("reset_b_valid", 64'(ifb.out_valid), 64'd0);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", 64'(ifa.in_ready), 64'd1);

    // Single item, two-edge latency
    send_a(6'd50, 2'b00);
    chk("t1_valid", 64'(ifa.out_valid), 64'd1);
    chk("t1_vec",   ifa.out_vec,        64'd1 << 50);
    chk("t1_win",   64'(ifa.out_win),   64'h0008);
    chk("t1_oor",   64'(ifa.out_oor),   64'd0);
    chk("t1_seq",   64'(ifa.out_seq),   64'd0);
    tick();
    chk("t1_drain", 64'(ifa.out_valid), 64'd0);

    // Back-to-back, full throughput
    pulse_reset();
    for (int c = 0; c < 6; c++) begin
      ifa.in_valid = (c < 4);
      ifa.in_idx   = 6'(c);
      ifa.in_mode  = 2'b00;
      #1;
      chk("b2b_in_ready", 64'(ifa.in_ready), 64'd1);
      tick();
      if (c >= 1 && c <= 4) begin
        chk("b2b_valid", 64'(ifa.out_valid), 64'd1);
        chk("b2b_vec",   ifa.out_vec,        64'd1 << (c - 1));
        chk("b2b_seq",   64'(ifa.out_seq),   64'(c - 1));
      end
    end
    chk("b2b_idle", 64'(ifa.out_valid), 64'd0);

    // Modes, default configuration
    send_a(6'd4, 2'b01);
    chk("low4_vec", ifa.out_vec, 64'h1F);
    chk("low4_oor", 64'(ifa.out_oor), 64'd0);
    tick();
    send_a(6'd4, 2'b10);
    chk("high4_vec", ifa.out_vec, 64'hFFFF_FFFF_FFFF_FFF0);
    chk("high4_win", 64'(ifa.out_win), 64'hFFFF);
    tick();
    send_a(6'd4, 2'b11);
    chk("zero4_vec", ifa.out_vec, 64'd0);
    tick();
    send_a(6'd63, 2'b00);
    chk("one63_vec", ifa.out_vec, 64'h8000_0000_0000_0000);
    chk("one63_win", 64'(ifa.out_win), 64'd0);
    chk("one63_oor", 64'(ifa.out_oor), 64'd0);
    tick();
    send_a(6'd63, 2'b01);
    chk("low63_vec", ifa.out_vec, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    send_a(6'd63, 2'b10);
    chk("high63_vec", ifa.out_vec, 64'h8000_0000_0000_0000);
    tick();
    send_a(6'd47, 2'b00);
    chk("one47_win", 64'(ifa.out_win), 64'h0001);
    tick();

    // 40-bit mask instance: out-of-range handling
    send_b(6'd45, 2'b01);
    chk("b45_low_vec", ifb.out_vec, 64'hFF_FFFF_FFFF);
    chk("b45_low_oor", 64'(ifb.out_oor), 64'd1);
    chk("b45_low_win", 64'(ifb.out_win), 64'hFFFF);
    tick();
    send_b(6'd45, 2'b00);
    chk("b45_one_vec", ifb.out_vec, 64'd0);
    chk("b45_one_oor", 64'(ifb.out_oor), 64'd1);
    tick();
    send_b(6'd45, 2'b10);
    chk("b45_high_vec", ifb.out_vec, 64'd0);
    chk("b45_high_oor", 64'(ifb.out_oor), 64'd1);
    tick();
    send_b(6'd40, 2'b11);
    chk("b40_zero_oor", 64'(ifb.out_oor), 64'd1);
    tick();
    send_b(6'd40, 2'b01);
    chk("b40_low_vec", ifb.out_vec, 64'hFF_FFFF_FFFF);
    chk("b40_low_oor", 64'(ifb.out_oor), 64'd1);
    tick();
    send_b(6'd39, 2'b00);
    chk("b39_one_vec", ifb.out_vec, 64'h80_0000_0000);
    chk("b39_one_oor", 64'(ifb.out_oor), 64'd0);
    tick();
    send_b(6'd39, 2'b10);
    chk("b39_high_vec", ifb.out_vec, 64'h80_0000_0000);
    tick();
    send_b(6'd8, 2'b00);
    chk("b8_win", 64'(ifb.out_win), 64'h0001);
    tick();

    // Backpressure
    pulse_reset();
    ifa.out_ready = 1'b0;
    ifa.in_valid  = 1'b1;
    ifa.in_mode   = 2'b00;
    ifa.in_idx    = 6'd10;
    #1;
    chk("bp_rdy0", 64'(ifa.in_ready), 64'd1);
    tick();
    ifa.in_idx = 6'd11;
    #1;
    chk("bp_rdy1", 64'(ifa.in_ready), 64'd1);
    tick();
    ifa.in_idx = 6'd12;
    #1;
    chk("bp_full_rdy", 64'(ifa.in_ready), 64'd0);
    chk("bp_full_vec", ifa.out_vec, 64'd1 << 10);
    chk("bp_full_seq", 64'(ifa.out_seq), 64'd0);
    repeat (2) begin
      tick();
      chk("bp_hold_valid", 64'(ifa.out_valid), 64'd1);
      chk("bp_hold_vec",   ifa.out_vec,        64'd1 << 10);
      chk("bp_hold_seq",   64'(ifa.out_seq),   64'd0);
      chk("bp_hold_rdy",   64'(ifa.in_ready),  64'd0);
    end
    ifa.out_ready = 1'b1;
    #1;
    chk("bp_rdy_comb", 64'(ifa.in_ready), 64'd1);
    tick();
    ifa.in_valid = 1'b0;
    chk("bp_item1_vec", ifa.out_vec, 64'd1 << 11);
    chk("bp_item1_seq", 64'(ifa.out_seq), 64'd1);
    tick();
    chk("bp_item2_valid", 64'(ifa.out_valid), 64'd1);
    chk("bp_item2_vec", ifa.out_vec, 64'd1 << 12);
    chk("bp_item2_seq", 64'(ifa.out_seq), 64'd2);
    tick();
    chk("bp_drained", 64'(ifa.out_valid), 64'd0);

    // Reset with two items in flight
    ifa.out_ready = 1'b0;
    ifa.in_valid  = 1'b1;
    ifa.in_idx    = 6'd20;
    tick();
    ifa.in_idx = 6'd21;
    tick();
    ifa.in_valid = 1'b0;
    chk("rf_pre_valid", 64'(ifa.out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("rf_async_valid", 64'(ifa.out_valid), 64'd0);
    chk("rf_async_vec",   ifa.out_vec,        64'd0);
    chk("rf_async_seq",   64'(ifa.out_seq),   64'd0);
    tick();
    rst = 1'b0;
    ifa.out_ready = 1'b1;
    send_a(6'd7, 2'b00);
    chk("rf_post_vec", ifa.out_vec, 64'd1 << 7);
    chk("rf_post_seq", 64'(ifa.out_seq), 64'd0);
    tick();
    chk("rf_no_ghost", 64'(ifa.out_valid), 64'd0);

    // Sequence tag wrap over 257 items
    pulse_reset();
    n_sent = 0;
    n_got  = 0;
    for (int c = 0; c < 262; c++) begin
      ifa.in_valid = (n_sent < 257);
      ifa.in_idx   = 6'(n_sent % 64);
      ifa.in_mode  = 2'b00;
      #1;
      fire = ifa.in_valid && ifa.in_ready;
      tick();
      if (fire) n_sent++;
      if (ifa.out_valid) begin
        chk("wrap_seq", 64'(ifa.out_seq), 64'(n_got % 256));
        chk("wrap_vec", ifa.out_vec, 64'd1 << (n_got % 64));
        n_got++;
      end
    end
    ifa.in_valid = 1'b0;
    chk("wrap_count", 64'(n_got), 64'd257);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
